// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: display mode encodings, default field width and the lap record.
package stopwatch_pkg;

    localparam int unsigned DEF_DIGIT_W = 8;

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_REVIEW = 2'd2
    } mode_e;

    // One captured lap at the default field width, most significant field first.
    typedef struct packed {
        logic [DEF_DIGIT_W-1:0] m;
        logic [DEF_DIGIT_W-1:0] s;
        logic [DEF_DIGIT_W-1:0] ms;
    } lap_t;

endpackage

// File: rtl/lap_memory_if.sv
// Control, live-time and display signals between the counter/buttons and the lap stage.
interface lap_memory_if
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIGIT_W = DEF_DIGIT_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned IDX_W   = $clog2(DEPTH)
);
    logic               run;
    logic               lap_req;
    logic               resume_req;
    logic               review_req;
    logic               next_req;
    logic               clr_req;
    logic [DIGIT_W-1:0] ms;
    logic [DIGIT_W-1:0] s;
    logic [DIGIT_W-1:0] m;
    logic [DIGIT_W-1:0] out_ms;
    logic [DIGIT_W-1:0] out_s;
    logic [DIGIT_W-1:0] out_m;
    logic [1:0]         mode;
    logic [IDX_W:0]     lap_cnt;
    logic [IDX_W-1:0]   view_idx;
    logic               ovf;

    modport master (
        output run, lap_req, resume_req, review_req, next_req, clr_req, ms, s, m,
        input  out_ms, out_s, out_m, mode, lap_cnt, view_idx, ovf
    );

    modport slave (
        input  run, lap_req, resume_req, review_req, next_req, clr_req, ms, s, m,
        output out_ms, out_s, out_m, mode, lap_cnt, view_idx, ovf
    );

endinterface

// File: rtl/lap_ring.sv
// Ring buffer of captured laps with an age-indexed read port (age 0 = oldest valid entry).
module lap_ring
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIGIT_W = DEF_DIGIT_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned IDX_W   = $clog2(DEPTH)
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [3*DIGIT_W-1:0] wr_data,
    input  logic [IDX_W-1:0]     rd_age,
    output logic [3*DIGIT_W-1:0] rd_data,
    output logic [IDX_W:0]       lap_cnt,
    output logic                 ovf
);

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   FULL     = (IDX_W + 1)'(DEPTH);

    logic [3*DIGIT_W-1:0] entries_q [DEPTH];
    logic [IDX_W-1:0]     wr_ptr_q;
    logic [IDX_W:0]       cnt_q;
    logic                 ovf_q;
    logic [IDX_W:0]       base;
    logic [IDX_W:0]       addr;

    // Operands stay below 2*DEPTH, so one conditional subtract reduces modulo DEPTH.
    function automatic logic [IDX_W:0] wrap(input logic [IDX_W:0] v);
        return (v >= FULL) ? v - FULL : v;
    endfunction

    // Capture, count and overflow tracking; clear empties the ring but keeps entry contents.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (wr_en) begin
            entries_q[wr_ptr_q] <= wr_data;
            wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + IDX_W'(1);
            if (cnt_q == FULL) ovf_q <= 1'b1;
            else               cnt_q <= cnt_q + (IDX_W + 1)'(1);
        end
    end

    // Oldest valid entry sits at wr_ptr - lap_cnt; add the requested age on top of it.
    always_comb begin
        base    = wrap({1'b0, wr_ptr_q} + FULL - cnt_q);
        addr    = wrap(base + {1'b0, rd_age});
        rd_data = entries_q[addr[IDX_W-1:0]];
    end

    assign lap_cnt = cnt_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/lap_memory.sv
// Lap capture/recall stage: live pass-through, frozen lap display and browsing of stored laps.
module lap_memory
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIGIT_W = DEF_DIGIT_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned IDX_W   = $clog2(DEPTH)
) (
    input logic         mclk,
    input logic         rst_n,
    lap_memory_if.slave bus
);

    mode_e                mode_q;
    logic [IDX_W-1:0]     view_q;
    logic                 run_q;
    logic [IDX_W:0]       lap_cnt;
    logic                 ovf;
    logic                 lap_do;
    logic [IDX_W:0]       last_age_full;
    logic [IDX_W-1:0]     last_age;
    logic [IDX_W-1:0]     rd_age;
    logic [3*DIGIT_W-1:0] rd_data;

    // A lap is taken only when it wins arbitration and the watch is running outside REVIEW.
    assign lap_do        = bus.lap_req && !bus.clr_req && bus.run && (mode_q != MODE_REVIEW);
    assign last_age_full = lap_cnt - (IDX_W + 1)'(1);
    assign last_age      = last_age_full[IDX_W-1:0];
    // HOLD shows the newest entry, which is the one of age lap_cnt-1.
    assign rd_age        = (mode_q == MODE_REVIEW) ? view_q : last_age;

    lap_ring #(
        .DIGIT_W (DIGIT_W),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W)
    ) u_ring (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .clr     (bus.clr_req),
        .wr_en   (lap_do),
        .wr_data ({bus.m, bus.s, bus.ms}),
        .rd_age  (rd_age),
        .rd_data (rd_data),
        .lap_cnt (lap_cnt),
        .ovf     (ovf)
    );

    // Mode FSM and view pointer; requests arbitrated clr > lap > review > resume > next.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            mode_q <= MODE_LIVE;
            view_q <= '0;
            run_q  <= 1'b0;
        end else begin
            run_q <= bus.run;
            if (bus.clr_req) begin
                mode_q <= MODE_LIVE;
                view_q <= '0;
            end else if (mode_q == MODE_REVIEW && bus.run && !run_q) begin
                mode_q <= MODE_LIVE;
            end else if (bus.lap_req) begin
                if (lap_do) mode_q <= MODE_HOLD;
            end else if (bus.review_req) begin
                if (mode_q == MODE_REVIEW) begin
                    mode_q <= MODE_LIVE;
                end else if (!bus.run && lap_cnt != '0) begin
                    mode_q <= MODE_REVIEW;
                    view_q <= '0;
                end
            end else if (bus.resume_req) begin
                if (mode_q == MODE_HOLD) mode_q <= MODE_LIVE;
            end else if (bus.next_req) begin
                if (mode_q == MODE_REVIEW) begin
                    view_q <= (view_q == last_age) ? '0 : view_q + IDX_W'(1);
                end
            end
        end
    end

    // Display mux: live time passes straight through, otherwise the selected ring entry.
    always_comb begin
        bus.out_ms = bus.ms;
        bus.out_s  = bus.s;
        bus.out_m  = bus.m;
        unique case (mode_q)
            MODE_HOLD, MODE_REVIEW: begin
                bus.out_ms = rd_data[DIGIT_W-1:0];
                bus.out_s  = rd_data[2*DIGIT_W-1:DIGIT_W];
                bus.out_m  = rd_data[3*DIGIT_W-1:2*DIGIT_W];
            end
            default: ;
        endcase
    end

    assign bus.mode     = mode_q;
    assign bus.lap_cnt  = lap_cnt;
    assign bus.view_idx = view_q;
    assign bus.ovf      = ovf;

endmodule

// File: tb/tb_lap_memory.sv
// Scoreboarded bench for lap_memory: a queue-based lap model predicts every cycle.
module tb_lap_memory;
    import stopwatch_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        lap_t disp;
        int   mode;
        int   cnt;
        int   view;
        int   ovf;
    } exp_t;

    logic mclk;
    logic rst_n;
    lap_memory_if #(.DIGIT_W(8), .DEPTH(DEPTH)) bus ();

    lap_memory #(.DIGIT_W(8), .DEPTH(DEPTH)) dut (
        .mclk  (mclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    int   n_chk = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    lap_t m_laps[$];
    int   m_mode = 0;
    int   m_view = 0;
    int   m_ovf  = 0;
    logic m_run_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: laps kept oldest-first in a queue, trimmed to DEPTH.
    task automatic model_edge();
        exp_t e;
        if (!rst_n) begin
            m_laps.delete();
            m_mode  = 0;
            m_view  = 0;
            m_ovf   = 0;
            m_run_q = 1'b0;
        end else begin
            if (bus.clr_req) begin
                m_laps.delete();
                m_mode = 0;
                m_view = 0;
                m_ovf  = 0;
            end else if (m_mode == 2 && bus.run && !m_run_q) begin
                m_mode = 0;
            end else if (bus.lap_req) begin
                if (bus.run && m_mode != 2) begin
                    if (m_laps.size() == DEPTH) begin
                        void'(m_laps.pop_front());
                        m_ovf = 1;
                    end
                    m_laps.push_back('{m: bus.m, s: bus.s, ms: bus.ms});
                    m_mode = 1;
                end
            end else if (bus.review_req) begin
                if (m_mode == 2) m_mode = 0;
                else if (!bus.run && m_laps.size() > 0) begin
                    m_mode = 2;
                    m_view = 0;
                end
            end else if (bus.resume_req) begin
                if (m_mode == 1) m_mode = 0;
            end else if (bus.next_req) begin
                if (m_mode == 2) m_view = (m_view == m_laps.size() - 1) ? 0 : m_view + 1;
            end
            m_run_q = bus.run;
        end
        if (m_mode == 1)      e.disp = m_laps[m_laps.size() - 1];
        else if (m_mode == 2) e.disp = m_laps[m_view];
        else                  e.disp = '{m: bus.m, s: bus.s, ms: bus.ms};
        e.mode = m_mode;
        e.cnt  = m_laps.size();
        e.view = m_view;
        e.ovf  = m_ovf;
        sb_q.push_back(e);
    endtask

    // One clock: predict, clock, compare everything, then drop the request pulses.
    task automatic cycle();
        exp_t e;
        model_edge();
        @(posedge mclk);
        #1;
        e = sb_q.pop_front();
        check("disp", 32'({bus.out_m, bus.out_s, bus.out_ms}), 32'(e.disp));
        check("mode", 32'(bus.mode), e.mode);
        check("lap_cnt", 32'(bus.lap_cnt), e.cnt);
        check("view_idx", 32'(bus.view_idx), e.view);
        check("ovf", 32'(bus.ovf), e.ovf);
        bus.lap_req    = 1'b0;
        bus.resume_req = 1'b0;
        bus.review_req = 1'b0;
        bus.next_req   = 1'b0;
        bus.clr_req    = 1'b0;
    endtask

    initial begin
        logic [7:0] walk [4];
        walk[0] = 8'h03; walk[1] = 8'h04; walk[2] = 8'h05; walk[3] = 8'h02;
        rst_n = 1'b0;
        bus.run = 1'b1;
        bus.lap_req = 1'b0; bus.resume_req = 1'b0; bus.review_req = 1'b0;
        bus.next_req = 1'b0; bus.clr_req = 1'b0;
        bus.ms = 8'h12; bus.s = 8'h34; bus.m = 8'h05;
        cycle();
        cycle();

        // Reset then LIVE
        rst_n = 1'b1;
        cycle();
        check("rst_out_ms", 32'(bus.out_ms), 32'h12);
        check("rst_out_s", 32'(bus.out_s), 32'h34);
        check("rst_out_m", 32'(bus.out_m), 32'h05);
        check("rst_mode", 32'(bus.mode), 0);
        check("rst_cnt", 32'(bus.lap_cnt), 0);

        // Single lap, then resume
        bus.m = 8'h01; bus.s = 8'h02; bus.ms = 8'h03; bus.lap_req = 1'b1;
        cycle();
        bus.m = 8'h33; bus.s = 8'h44; bus.ms = 8'h55;
        #1;
        check("lap_hold", 32'({bus.out_m, bus.out_s, bus.out_ms}), 32'h010203);
        check("lap_mode", 32'(bus.mode), 1);
        check("lap_cnt", 32'(bus.lap_cnt), 1);
        cycle();
        bus.resume_req = 1'b1;
        cycle();
        check("resume_live", 32'({bus.out_m, bus.out_s, bus.out_ms}), 32'h334455);
        check("resume_mode", 32'(bus.mode), 0);
        bus.ms = 8'h56;
        #1;
        check("live_zero_lat", 32'(bus.out_ms), 32'h56);

        // Overflow and browsing
        bus.clr_req = 1'b1;
        cycle();
        for (int i = 1; i <= 5; i++) begin
            bus.ms = 8'(i);
            bus.lap_req = 1'b1;
            cycle();
        end
        bus.run = 1'b0;
        cycle();
        bus.review_req = 1'b1;
        cycle();
        check("rev_mode", 32'(bus.mode), 2);
        check("rev_view0", 32'(bus.view_idx), 0);
        check("rev_oldest", 32'(bus.out_ms), 32'h02);
        for (int k = 0; k < 4; k++) begin
            bus.next_req = 1'b1;
            cycle();
            check("rev_next", 32'(bus.out_ms), 32'(walk[k]));
        end
        check("ovf_cnt", 32'(bus.lap_cnt), 4);
        check("ovf_flag", 32'(bus.ovf), 1);

        // Run rising while in REVIEW
        bus.run = 1'b1;
        cycle();
        check("run_rise_live", 32'(bus.mode), 0);

        // Simultaneous requests
        bus.ms = 8'h77; bus.lap_req = 1'b1; bus.clr_req = 1'b1;
        cycle();
        check("lapclr_cnt", 32'(bus.lap_cnt), 0);
        check("lapclr_mode", 32'(bus.mode), 0);
        bus.ms = 8'h66; bus.lap_req = 1'b1; bus.review_req = 1'b1;
        cycle();
        check("laprev_mode", 32'(bus.mode), 1);
        check("laprev_cnt", 32'(bus.lap_cnt), 1);
        check("laprev_disp", 32'(bus.out_ms), 32'h66);

        // Guards
        bus.clr_req = 1'b1;
        cycle();
        bus.run = 1'b0; bus.review_req = 1'b1;
        cycle();
        check("rev_empty", 32'(bus.mode), 0);
        bus.lap_req = 1'b1;
        cycle();
        check("lap_stopped_cnt", 32'(bus.lap_cnt), 0);
        check("lap_stopped_mode", 32'(bus.mode), 0);

        // Reset while in REVIEW
        bus.run = 1'b1; bus.lap_req = 1'b1;
        cycle();
        bus.run = 1'b0;
        cycle();
        bus.review_req = 1'b1;
        cycle();
        check("pre_rst_mode", 32'(bus.mode), 2);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("midrst_mode", 32'(bus.mode), 0);
        check("midrst_cnt", 32'(bus.lap_cnt), 0);
        check("midrst_ovf", 32'(bus.ovf), 0);
        bus.review_req = 1'b1;
        cycle();
        check("midrst_rev", 32'(bus.mode), 0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) bus.run = ~bus.run;
            bus.ms = 8'($urandom); bus.s = 8'($urandom); bus.m = 8'($urandom);
            bus.lap_req    = ($urandom_range(0, 3) == 0);
            bus.resume_req = ($urandom_range(0, 4) == 0);
            bus.review_req = ($urandom_range(0, 4) == 0);
            bus.next_req   = ($urandom_range(0, 2) == 0);
            bus.clr_req    = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
